// File: rtl/openframe_gpio_cfg_sequencer_pkg.sv
// rtl/openframe_gpio_cfg_sequencer_pkg.sv - shared field layout, reset value and FSM encoding
package openframe_gpio_cfg_sequencer_pkg;

  localparam int CFG_W = 10;

  localparam int DM_MSB      = 9;
  localparam int DM_LSB      = 7;
  localparam int INP_DIS     = 6;
  localparam int IB_MODE_SEL = 5;
  localparam int VTRIP_SEL   = 4;
  localparam int SLOW_SEL    = 3;
  localparam int AN_EN       = 2;
  localparam int AN_SEL      = 1;
  localparam int AN_POL      = 0;

  localparam logic [CFG_W-1:0] CFG_RESET = 10'b001_0000000;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HOLD    = 2'd1,
    S_SWEEP   = 2'd2,
    S_RELEASE = 2'd3
  } state_e;

endpackage

// File: rtl/openframe_gpio_cfg_sequencer_bank.sv
// rtl/openframe_gpio_cfg_sequencer_bank.sv - NPADS x CFG_W config register array, one indexed write port
module openframe_gpio_cfg_sequencer_bank
  import openframe_gpio_cfg_sequencer_pkg::*;
#(
  parameter int NPADS = 44,
  parameter int PAD_W = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [PAD_W-1:0]             wr_idx,
  input  logic [CFG_W-1:0]             wr_data,
  output logic [NPADS-1:0][CFG_W-1:0]  mem
);

  logic [NPADS-1:0][CFG_W-1:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_idx] = wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_q <= {NPADS{CFG_RESET}};
    else     mem_q <= mem_d;
  end

  assign mem = mem_q;

endmodule

// File: rtl/openframe_gpio_cfg_sequencer.sv
// rtl/openframe_gpio_cfg_sequencer.sv - shadow/live GPIO pad config with glitch-safe holdover apply sequence
module openframe_gpio_cfg_sequencer
  import openframe_gpio_cfg_sequencer_pkg::*;
#(
  parameter int NPADS      = 44,
  parameter int PAD_W      = 6,
  parameter int HOLD_CYC   = 4,
  parameter int SETTLE_CYC = 4
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [PAD_W-1:0]  cfg_pad,
  input  logic [CFG_W-1:0]  cfg_data,
  output logic              cfg_err,
  input  logic [PAD_W-1:0]  rd_pad,
  output logic [CFG_W-1:0]  rd_data,
  input  logic              apply_req,
  output logic              busy,
  output logic              apply_done,
  output logic [NPADS-1:0]  gpio_dm2,
  output logic [NPADS-1:0]  gpio_dm1,
  output logic [NPADS-1:0]  gpio_dm0,
  output logic [NPADS-1:0]  gpio_inp_dis,
  output logic [NPADS-1:0]  gpio_ib_mode_sel,
  output logic [NPADS-1:0]  gpio_vtrip_sel,
  output logic [NPADS-1:0]  gpio_slow_sel,
  output logic [NPADS-1:0]  gpio_analog_en,
  output logic [NPADS-1:0]  gpio_analog_sel,
  output logic [NPADS-1:0]  gpio_analog_pol,
  output logic [NPADS-1:0]  gpio_holdover
);

  localparam int CNT_MAX = (HOLD_CYC > SETTLE_CYC) ? HOLD_CYC : SETTLE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [PAD_W-1:0] LAST_IDX = PAD_W'(NPADS - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PAD_W-1:0]   idx_q, idx_d;
  logic               pending_q, pending_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               cfg_in_range, cfg_accept, shadow_we, live_we, hold;
  logic [NPADS-1:0][CFG_W-1:0] shadow, live;

  assign cfg_in_range = 32'(cfg_pad) < NPADS;

  openframe_gpio_cfg_sequencer_bank #(.NPADS(NPADS), .PAD_W(PAD_W)) u_shadow (
    .clk(wb_clk_i), .rst(wb_rst_i), .wr_en(shadow_we), .wr_idx(cfg_pad),
    .wr_data(cfg_data), .mem(shadow)
  );

  // Live copy port: the sweep index drives both the shadow read and the live write.
  openframe_gpio_cfg_sequencer_bank #(.NPADS(NPADS), .PAD_W(PAD_W)) u_live (
    .clk(wb_clk_i), .rst(wb_rst_i), .wr_en(live_we), .wr_idx(idx_q),
    .wr_data(shadow[idx_q]), .mem(live)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    err_d     = cfg_accept && !cfg_in_range;
    if (state_q != S_IDLE && apply_req) pending_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (apply_req || pending_q) begin
          state_d   = S_HOLD;
          cnt_d     = CNT_W'(HOLD_CYC - 1);
          pending_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_SWEEP;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_SWEEP: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_RELEASE;
          cnt_d   = CNT_W'(SETTLE_CYC - 1);
        end else begin
          idx_d = idx_q + PAD_W'(1);
        end
      end
      S_RELEASE: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready  = (state_q == S_IDLE);
    busy       = (state_q != S_IDLE);
    hold       = (state_q == S_HOLD) || (state_q == S_SWEEP);
    cfg_accept = cfg_valid && cfg_ready;
    shadow_we  = cfg_accept && cfg_in_range;
    live_we    = (state_q == S_SWEEP);
    apply_done = done_q;
    cfg_err    = err_q;
  end

  always_comb begin
    rd_data = CFG_RESET;
    if (32'(rd_pad) < NPADS) rd_data = shadow[rd_pad];
  end

  always_comb begin
    gpio_dm2         = '0;
    gpio_dm1         = '0;
    gpio_dm0         = '0;
    gpio_inp_dis     = '0;
    gpio_ib_mode_sel = '0;
    gpio_vtrip_sel   = '0;
    gpio_slow_sel    = '0;
    gpio_analog_en   = '0;
    gpio_analog_sel  = '0;
    gpio_analog_pol  = '0;
    for (int p = 0; p < NPADS; p++) begin
      gpio_dm2[p]         = live[p][DM_MSB];
      gpio_dm1[p]         = live[p][DM_MSB-1];
      gpio_dm0[p]         = live[p][DM_LSB];
      gpio_inp_dis[p]     = live[p][INP_DIS];
      gpio_ib_mode_sel[p] = live[p][IB_MODE_SEL];
      gpio_vtrip_sel[p]   = live[p][VTRIP_SEL];
      gpio_slow_sel[p]    = live[p][SLOW_SEL];
      gpio_analog_en[p]   = live[p][AN_EN];
      gpio_analog_sel[p]  = live[p][AN_SEL];
      gpio_analog_pol[p]  = live[p][AN_POL];
    end
    gpio_holdover = {NPADS{hold}};
  end

endmodule

// File: tb/tb_openframe_gpio_cfg_sequencer.sv
// tb/tb_openframe_gpio_cfg_sequencer.sv - table-driven and sequence checks for openframe_gpio_cfg_sequencer
module tb_openframe_gpio_cfg_sequencer;
  import openframe_gpio_cfg_sequencer_pkg::*;

  localparam int NPADS = 44;
  localparam int PAD_W = 6;
  localparam logic [NPADS-1:0] ALL1 = '1;

  logic              wb_clk_i, wb_rst_i;
  logic              cfg_valid, cfg_ready, cfg_err, apply_req, busy, apply_done;
  logic [PAD_W-1:0]  cfg_pad, rd_pad;
  logic [CFG_W-1:0]  cfg_data, rd_data;
  logic [NPADS-1:0]  gpio_dm2, gpio_dm1, gpio_dm0, gpio_inp_dis, gpio_ib_mode_sel;
  logic [NPADS-1:0]  gpio_vtrip_sel, gpio_slow_sel, gpio_analog_en, gpio_analog_sel;
  logic [NPADS-1:0]  gpio_analog_pol, gpio_holdover;

  openframe_gpio_cfg_sequencer #(.NPADS(NPADS), .PAD_W(PAD_W), .HOLD_CYC(4), .SETTLE_CYC(4)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_pad(cfg_pad), .cfg_data(cfg_data),
    .cfg_err(cfg_err), .rd_pad(rd_pad), .rd_data(rd_data),
    .apply_req(apply_req), .busy(busy), .apply_done(apply_done),
    .gpio_dm2(gpio_dm2), .gpio_dm1(gpio_dm1), .gpio_dm0(gpio_dm0),
    .gpio_inp_dis(gpio_inp_dis), .gpio_ib_mode_sel(gpio_ib_mode_sel),
    .gpio_vtrip_sel(gpio_vtrip_sel), .gpio_slow_sel(gpio_slow_sel),
    .gpio_analog_en(gpio_analog_en), .gpio_analog_sel(gpio_analog_sel),
    .gpio_analog_pol(gpio_analog_pol), .gpio_holdover(gpio_holdover)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  int vectors = 0;
  int miscompares = 0;
  logic [CFG_W-1:0] sh_m [NPADS];
  logic [CFG_W-1:0] live_m [NPADS];

  typedef struct {
    logic             valid;
    logic [PAD_W-1:0] pad;
    logic [CFG_W-1:0] data;
    logic             exp_err;
    logic [CFG_W-1:0] exp_rd;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  function automatic logic [NPADS-1:0] exp_bus(input int b);
    logic [NPADS-1:0] r;
    for (int p = 0; p < NPADS; p++) r[p] = live_m[p][b];
    return r;
  endfunction

  function automatic logic [10*NPADS-1:0] snap();
    return {gpio_dm2, gpio_dm1, gpio_dm0, gpio_inp_dis, gpio_ib_mode_sel, gpio_vtrip_sel,
            gpio_slow_sel, gpio_analog_en, gpio_analog_sel, gpio_analog_pol};
  endfunction

  task automatic check_live(input string tag);
    chk({tag, " dm2"},     gpio_dm2,         exp_bus(9));
    chk({tag, " dm1"},     gpio_dm1,         exp_bus(8));
    chk({tag, " dm0"},     gpio_dm0,         exp_bus(7));
    chk({tag, " inp_dis"}, gpio_inp_dis,     exp_bus(6));
    chk({tag, " ib_mode"}, gpio_ib_mode_sel, exp_bus(5));
    chk({tag, " vtrip"},   gpio_vtrip_sel,   exp_bus(4));
    chk({tag, " slow"},    gpio_slow_sel,    exp_bus(3));
    chk({tag, " an_en"},   gpio_analog_en,   exp_bus(2));
    chk({tag, " an_sel"},  gpio_analog_sel,  exp_bus(1));
    chk({tag, " an_pol"},  gpio_analog_pol,  exp_bus(0));
  endtask

  task automatic write_pad(input int pad, input logic [CFG_W-1:0] data);
    cfg_valid = 1'b1;
    cfg_pad   = PAD_W'(pad);
    cfg_data  = data;
    tick();
    cfg_valid = 1'b0;
    if (pad < NPADS) sh_m[pad] = data;
  endtask

  initial begin
    int first_done, second_done, done_cnt, hold_cnt, pad5_c, glitch, ready_bad, rd_bad;
    logic prev_hold;
    logic [10*NPADS-1:0] prev_snap;

    tbl[0] = '{1'b1, 6'd5,  10'h341, 1'b0, 10'h341};
    tbl[1] = '{1'b1, 6'd50, 10'h3FF, 1'b1, 10'h080};
    tbl[2] = '{1'b1, 6'd63, 10'h155, 1'b1, 10'h080};
    tbl[3] = '{1'b1, 6'd0,  10'h2AA, 1'b0, 10'h2AA};
    tbl[4] = '{1'b1, 6'd43, 10'h1C3, 1'b0, 10'h1C3};
    tbl[5] = '{1'b0, 6'd44, 10'h000, 1'b0, 10'h080};
    tbl[6] = '{1'b0, 6'd5,  10'h000, 1'b0, 10'h341};
    tbl[7] = '{1'b1, 6'd1,  10'h000, 1'b0, 10'h000};

    for (int p = 0; p < NPADS; p++) begin
      sh_m[p]   = CFG_RESET;
      live_m[p] = CFG_RESET;
    end

    wb_rst_i = 1'b1; cfg_valid = 1'b0; cfg_pad = '0; cfg_data = '0; rd_pad = '0; apply_req = 1'b0;
    tick(); tick();
    wb_rst_i = 1'b0;
    tick();

    // Reset state
    check_live("rst");
    chk("rst holdover", gpio_holdover, '0);
    chk("rst ready", cfg_ready, 1);
    chk("rst busy", busy, 0);
    chk("rst done", apply_done, 0);
    chk("rst err", cfg_err, 0);
    chk("rst rd_data", rd_data, CFG_RESET);

    // Shadow write / readback table
    for (int i = 0; i < 8; i++) begin
      cfg_valid = tbl[i].valid;
      cfg_pad   = tbl[i].pad;
      cfg_data  = tbl[i].data;
      rd_pad    = tbl[i].pad;
      #3;
      chk($sformatf("tbl%0d ready", i), cfg_ready, 1);
      tick();
      cfg_valid = 1'b0;
      chk($sformatf("tbl%0d err", i), cfg_err, tbl[i].exp_err);
      chk($sformatf("tbl%0d rd_data", i), rd_data, tbl[i].exp_rd);
      if (tbl[i].valid && tbl[i].pad < NPADS) sh_m[tbl[i].pad] = tbl[i].data;
    end
    tick();
    chk("err single pulse", cfg_err, 0);
    check_live("pre-apply live unchanged");

    // Single apply: holdover span, pad 5 timing, done latency
    apply_req = 1'b1;
    tick();
    apply_req = 1'b0;
    chk("apply busy c0", busy, 1);
    first_done = -1; done_cnt = 0; pad5_c = -1; glitch = 0;
    hold_cnt = (gpio_holdover == ALL1) ? 1 : 0;
    prev_hold = gpio_holdover[0]; prev_snap = snap();
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (gpio_holdover == ALL1) hold_cnt++;
      if (apply_done) begin done_cnt++; if (first_done < 0) first_done = c; end
      if (pad5_c < 0 && {gpio_dm2[5], gpio_dm1[5], gpio_dm0[5]} == 3'b110) pad5_c = c;
      if (snap() != prev_snap && !prev_hold) glitch++;
      prev_hold = gpio_holdover[0]; prev_snap = snap();
      if (c == 52) chk("apply busy at done", busy, 0);
    end
    for (int p = 0; p < NPADS; p++) live_m[p] = sh_m[p];
    chk("apply holdover cycles", hold_cnt, 48);
    chk("apply pad5 sweep cycle", pad5_c, 10);
    chk("apply done latency", first_done, 52);
    chk("apply done count", done_cnt, 1);
    chk("apply change outside holdover", glitch, 0);
    check_live("apply1");

    // Write held while busy waits for IDLE
    apply_req = 1'b1;
    tick();
    apply_req = 1'b0;
    ready_bad = 0; rd_bad = 0;
    for (int c = 1; c <= 53; c++) begin
      tick();
      if (c >= 4 && c <= 51) begin
        if (cfg_ready !== 1'b0) ready_bad++;
        if (rd_data !== CFG_RESET) rd_bad++;
      end
      if (c == 52) begin
        chk("held write done", apply_done, 1);
        chk("held write ready idle", cfg_ready, 1);
        chk("held write not yet", rd_data, CFG_RESET);
      end
      if (c == 53) begin
        chk("held write landed", rd_data, 10'h0F0);
        cfg_valid = 1'b0;
        sh_m[9] = 10'h0F0;
      end
      if (c == 3) begin
        cfg_valid = 1'b1; cfg_pad = 6'd9; cfg_data = 10'h0F0; rd_pad = 6'd9;
      end
    end
    chk("held write ready low while busy", ready_bad, 0);
    chk("held write shadow frozen", rd_bad, 0);

    // Simultaneous write+apply, then coalesced mid-sequence requests
    cfg_valid = 1'b1; cfg_pad = 6'd7; cfg_data = 10'h3C5; apply_req = 1'b1;
    tick();
    cfg_valid = 1'b0; apply_req = 1'b0;
    sh_m[7] = 10'h3C5;
    first_done = -1; second_done = -1; done_cnt = 0;
    for (int c = 1; c <= 115; c++) begin
      tick();
      apply_req = (c == 5 || c == 20 || c == 45);
      if (apply_done) begin
        done_cnt++;
        if (first_done < 0) first_done = c; else if (second_done < 0) second_done = c;
      end
      if (c == 52) chk("pend done not busy", busy, 0);
      if (c == 53) begin
        chk("pend relaunch busy", busy, 1);
        chk("pend relaunch holdover", gpio_holdover, ALL1);
      end
    end
    apply_req = 1'b0;
    for (int p = 0; p < NPADS; p++) live_m[p] = sh_m[p];
    chk("pend done count", done_cnt, 2);
    chk("pend first done", first_done, 52);
    chk("pend second done", second_done, 105);
    check_live("pend");

    // Asynchronous reset during sweep at idx 20
    write_pad(2, 10'h3FF);
    write_pad(30, 10'h3FF);
    apply_req = 1'b1;
    tick();
    apply_req = 1'b0;
    for (int c = 1; c <= 24; c++) tick();
    chk("mid pad2 dm swept", {gpio_dm2[2], gpio_dm1[2], gpio_dm0[2]}, 3'b111);
    chk("mid pad2 inp_dis swept", gpio_inp_dis[2], 1);
    chk("mid pad30 not swept", gpio_inp_dis[30], 0);
    chk("mid holdover", gpio_holdover, ALL1);
    #2 wb_rst_i = 1'b1;
    #1;
    for (int p = 0; p < NPADS; p++) begin
      sh_m[p]   = CFG_RESET;
      live_m[p] = CFG_RESET;
    end
    check_live("async rst");
    chk("async rst holdover", gpio_holdover, '0);
    chk("async rst busy", busy, 0);
    chk("async rst ready", cfg_ready, 1);
    #2 wb_rst_i = 1'b0;
    rd_pad = 6'd5;
    tick();
    chk("post rst shadow", rd_data, CFG_RESET);
    tick(); tick();
    chk("post rst stays idle", busy, 0);
    check_live("post rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
